execute_cycle: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX bundle (execute_info plus operand data and pc) produced by the decode stage, and applies operand forwarding. It computes the ALU result, resolves branches and jumps, and registers the result into the EX/MEM bundle for the memory stage. It also issues the PC redirect to fetch and keeps two branch statistics counters.

---
 rtl/execute_cycle_pkg.sv | 53 +++++
 rtl/execute_cycle_if.sv | 25 ++
 rtl/execute_cycle_alu.sv | 34 +++
 rtl/execute_cycle.sv | 136 +++++++++++++
 tb/tb_execute_cycle.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_cycle_pkg.sv
// Shared RV32I pipeline types: ID/EX and EX/MEM control bundles, ALU and branch opcodes.
package execute_cycle_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_ctrl_e;

  localparam logic [2:0] BRU_EQ   = 3'b000;
  localparam logic [2:0] BRU_NE   = 3'b001;
  localparam logic [2:0] BRU_JAL  = 3'b010;
  localparam logic [2:0] BRU_JALR = 3'b011;
  localparam logic [2:0] BRU_LT   = 3'b100;
  localparam logic [2:0] BRU_GE   = 3'b101;

  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;

  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic        is_pc;
    logic        op_b_sel;
    logic [31:0] imm;
    logic        bru_en;
    logic [2:0]  bru_op;
    logic        bru_unsign;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic        mem_wren;
    logic [1:0]  mem_size;
    logic        mem_unsign;
    logic        mem_load;
  } execute_info;

  typedef struct packed {
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic        mem_wren;
    logic [1:0]  mem_size;
    logic        mem_unsign;
    logic        mem_load;
  } memory_info;

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX and EX/MEM pipeline bundle seen by the execute stage.
// master: surrounding pipeline (drives ID/EX, consumes EX/MEM); slave: execute stage.
interface execute_cycle_if #(parameter int XLEN = 32);
  import execute_cycle_pkg::*;

  execute_info           execute_signals;
  logic [XLEN-1:0]       rs1_data_E;
  logic [XLEN-1:0]       rs2_data_E;
  logic [XLEN-1:0]       pc_E;

  memory_info            memory_signals;
  logic [XLEN-1:0]       alu_result_M;
  logic [XLEN-1:0]       store_data_M;
  logic [XLEN-1:0]       pc_M;

  modport master (
    output execute_signals, rs1_data_E, rs2_data_E, pc_E,
    input  memory_signals, alu_result_M, store_data_M, pc_M
  );

  modport slave (
    input  execute_signals, rs1_data_E, rs2_data_E, pc_E,
    output memory_signals, alu_result_M, store_data_M, pc_M
  );
endinterface

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I integer ALU; shift amount is b[4:0], arithmetic wraps.
module execute_cycle_alu
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_ctrl_e       alu_ctrl,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_LUI:  result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding, ALU, branch resolution, PC redirect, EX/MEM register
// and branch statistics counters.
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_E,
  input  logic             flush_E,
  execute_cycle_if.slave   pipe,
  input  logic [1:0]       forward_a_E,
  input  logic [1:0]       forward_b_E,
  input  logic [XLEN-1:0]  rd_data_W,
  output logic [4:0]       rd_addr_E,
  output logic             rd_wren_E,
  output logic             mem_load_E,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  execute_info     ex;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, imm_x, op_a, op_b, alu_y;
  logic [XLEN-1:0] jalr_sum, result_E;
  logic            is_eq, is_lt, taken, is_jump;
  memory_info      mem_d, mem_q;
  logic [XLEN-1:0] alu_result_q, store_data_q, pc_q;

  assign ex    = pipe.execute_signals;
  assign imm_x = XLEN'($signed(ex.imm));

  // Forward select 11 is unused and falls back to the ID/EX operand.
  always_comb begin
    case (forward_a_E)
      FWD_W:   rs1_fwd = rd_data_W;
      FWD_M:   rs1_fwd = alu_result_q;
      default: rs1_fwd = pipe.rs1_data_E;
    endcase
    case (forward_b_E)
      FWD_W:   rs2_fwd = rd_data_W;
      FWD_M:   rs2_fwd = alu_result_q;
      default: rs2_fwd = pipe.rs2_data_E;
    endcase
  end

  assign op_a = ex.is_pc    ? pipe.pc_E : rs1_fwd;
  assign op_b = ex.op_b_sel ? imm_x     : rs2_fwd;

  execute_cycle_alu #(.XLEN(XLEN)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .alu_ctrl (ex.alu_ctrl),
    .result   (alu_y)
  );

  assign is_eq = (rs1_fwd == rs2_fwd);
  assign is_lt = ex.bru_unsign ? (rs1_fwd < rs2_fwd)
                               : ($signed(rs1_fwd) < $signed(rs2_fwd));

  always_comb begin
    taken = 1'b0;
    case (ex.bru_op)
      BRU_EQ:   taken = is_eq;
      BRU_NE:   taken = !is_eq;
      BRU_JAL:  taken = 1'b1;
      BRU_JALR: taken = 1'b1;
      BRU_LT:   taken = is_lt;
      BRU_GE:   taken = !is_lt;
      default:  taken = 1'b0;
    endcase
  end

  assign jalr_sum       = rs1_fwd + imm_x;
  assign redirect_pc    = (ex.bru_op == BRU_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                  : pipe.pc_E + imm_x;
  assign redirect_valid = ex.bru_en && taken && !stall_E;

  assign is_jump  = ex.bru_en && ((ex.bru_op == BRU_JAL) || (ex.bru_op == BRU_JALR));
  assign result_E = is_jump ? pipe.pc_E + XLEN'(4) : alu_y;

  assign rd_addr_E  = ex.rd_addr;
  assign rd_wren_E  = ex.rd_wren;
  assign mem_load_E = ex.mem_load;

  always_comb begin
    mem_d            = '0;
    mem_d.rd_wren    = ex.rd_wren;
    mem_d.rd_addr    = ex.rd_addr;
    mem_d.mem_wren   = ex.mem_wren;
    mem_d.mem_size   = ex.mem_size;
    mem_d.mem_unsign = ex.mem_unsign;
    mem_d.mem_load   = ex.mem_load;
  end

  // Stall outranks flush so a held instruction is never lost to a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q        <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      pc_q         <= '0;
    end else if (!stall_E) begin
      if (flush_E) begin
        mem_q        <= '0;
        alu_result_q <= '0;
        store_data_q <= '0;
        pc_q         <= '0;
      end else begin
        mem_q        <= mem_d;
        alu_result_q <= result_E;
        store_data_q <= rs2_fwd;
        pc_q         <= pipe.pc_E;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (!stall_E) begin
      if (ex.bru_en)      branch_cnt <= branch_cnt + CNT_W'(1);
      if (redirect_valid) taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

  assign pipe.memory_signals = mem_q;
  assign pipe.alu_result_M   = alu_result_q;
  assign pipe.store_data_M   = store_data_q;
  assign pipe.pc_M           = pc_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed-vector bench for execute_cycle with hand-computed expectations.
module tb_execute_cycle;
  import execute_cycle_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_E = 1'b0;
  logic        flush_E = 1'b0;
  logic [1:0]  forward_a_E = 2'b00;
  logic [1:0]  forward_b_E = 2'b00;
  logic [31:0] rd_data_W = '0;
  logic [4:0]  rd_addr_E;
  logic        rd_wren_E, mem_load_E, redirect_valid;
  logic [31:0] redirect_pc, branch_cnt, taken_cnt;

  int n_vec = 0;
  int n_err = 0;
  execute_info ei;
  memory_info  me;

  execute_cycle_if #(.XLEN(32)) pipe ();

  execute_cycle #(.XLEN(32), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_E(stall_E), .flush_E(flush_E), .pipe(pipe),
    .forward_a_E(forward_a_E), .forward_b_E(forward_b_E), .rd_data_W(rd_data_W),
    .rd_addr_E(rd_addr_E), .rd_wren_E(rd_wren_E), .mem_load_E(mem_load_E),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive(input execute_info e, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    pipe.execute_signals = e;
    pipe.rs1_data_E      = a;
    pipe.rs2_data_E      = b;
    pipe.pc_E            = pc;
    #1;
  endtask

  task automatic test_reset();
    ei = '0;
    drive(ei, 32'h0, 32'h0, 32'h0);
    #2;
    n_vec++;
    if (pipe.memory_signals !== '0 || pipe.alu_result_M !== 32'h0 || pipe.store_data_M !== 32'h0 ||
        pipe.pc_M !== 32'h0 || branch_cnt !== 32'h0 || taken_cnt !== 32'h0 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: mem=%h alu=%h st=%h pc=%h bc=%0d tc=%0d rv=%b, required all 0",
               pipe.memory_signals, pipe.alu_result_M, pipe.store_data_M, pipe.pc_M,
               branch_cnt, taken_cnt, redirect_valid);
    end
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_add_fwd();
    ei = '0; ei.alu_ctrl = ALU_ADD; ei.rd_wren = 1'b1; ei.rd_addr = 5'd3;
    drive(ei, 32'd2, 32'd3, 32'h10);
    step();
    drive(ei, 32'd99, 32'd7, 32'h14);
    forward_a_E = 2'b10;
    #1;
    n_vec++;
    if (rd_wren_E !== 1'b1 || rd_addr_E !== 5'd3) begin
      n_err++;
      $display("FAIL add_hazard_outs: rd_wren_E=%b rd_addr_E=%0d, required 1/3", rd_wren_E, rd_addr_E);
    end
    step();
    forward_a_E = 2'b00;
    n_vec++;
    if (pipe.alu_result_M !== 32'd12 || pipe.store_data_M !== 32'd7 || pipe.pc_M !== 32'h14) begin
      n_err++;
      $display("FAIL add_fwd_m: alu=%h st=%h pc=%h, required 0000000c/00000007/00000014",
               pipe.alu_result_M, pipe.store_data_M, pipe.pc_M);
    end
    n_vec++;
    if (pipe.memory_signals.rd_wren !== 1'b1 || pipe.memory_signals.rd_addr !== 5'd3) begin
      n_err++;
      $display("FAIL add_rd_prop: rd_wren=%b rd_addr=%0d, required 1/3",
               pipe.memory_signals.rd_wren, pipe.memory_signals.rd_addr);
    end
  endtask

  task automatic test_alu_ops();
    alu_ctrl_e   t_op [10] = '{ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                               ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ADD};
    logic [31:0] t_a  [10] = '{32'd10, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000F0F0,
                               32'h80000000, 32'h80000000, 32'hF0, 32'hF0, 32'hFFFFFFFF};
    logic [31:0] t_b  [10] = '{32'd3, 32'h24, 32'd1, 32'd1, 32'h0000FF00,
                               32'd4, 32'd4, 32'h0F, 32'h3C, 32'd2};
    logic [31:0] t_y  [10] = '{32'd7, 32'h10, 32'd1, 32'd0, 32'h00000FF0,
                               32'h08000000, 32'hF8000000, 32'hFF, 32'h30, 32'd1};
    for (int i = 0; i < 10; i++) begin
      ei = '0; ei.alu_ctrl = t_op[i]; ei.rd_wren = 1'b1; ei.rd_addr = 5'd5;
      drive(ei, t_a[i], t_b[i], 32'h20);
      step();
      n_vec++;
      if (pipe.alu_result_M !== t_y[i]) begin
        n_err++;
        $display("FAIL alu_op[%0d] %s: got %h, required %h", i, t_op[i].name(), pipe.alu_result_M, t_y[i]);
      end
    end
    ei = '0; ei.alu_ctrl = ALU_LUI; ei.op_b_sel = 1'b1; ei.imm = 32'h12345000;
    drive(ei, 32'h55, 32'h66, 32'h24);
    step();
    n_vec++;
    if (pipe.alu_result_M !== 32'h12345000) begin
      n_err++;
      $display("FAIL alu_lui: got %h, required 12345000", pipe.alu_result_M);
    end
    ei = '0; ei.alu_ctrl = ALU_ADD; ei.is_pc = 1'b1; ei.op_b_sel = 1'b1; ei.imm = 32'h10;
    drive(ei, 32'h55, 32'h66, 32'h1000);
    step();
    n_vec++;
    if (pipe.alu_result_M !== 32'h1010) begin
      n_err++;
      $display("FAIL alu_auipc: got %h, required 00001010", pipe.alu_result_M);
    end
    ei = '0; ei.alu_ctrl = ALU_ADD;
    rd_data_W = 32'h100; forward_b_E = 2'b01;
    drive(ei, 32'h1, 32'h77, 32'h28);
    step();
    n_vec++;
    if (pipe.alu_result_M !== 32'h101 || pipe.store_data_M !== 32'h100) begin
      n_err++;
      $display("FAIL fwd_b_w: alu=%h st=%h, required 00000101/00000100", pipe.alu_result_M, pipe.store_data_M);
    end
    forward_b_E = 2'b00; forward_a_E = 2'b11;
    drive(ei, 32'h4, 32'h5, 32'h2C);
    step();
    forward_a_E = 2'b00;
    n_vec++;
    if (pipe.alu_result_M !== 32'h9) begin
      n_err++;
      $display("FAIL fwd_sel_11: got %h, required 00000009", pipe.alu_result_M);
    end
  endtask

  task automatic test_blt();
    ei = '0; ei.bru_en = 1'b1; ei.bru_op = BRU_LT; ei.imm = 32'h20;
    drive(ei, 32'hFFFFFFFF, 32'h1, 32'h100);
    n_vec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
      n_err++;
      $display("FAIL blt_signed: rv=%b pc=%h, required 1/00000120", redirect_valid, redirect_pc);
    end
    step();
    n_vec++;
    if (branch_cnt !== 32'd1 || taken_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL blt_signed_cnt: bc=%0d tc=%0d, required 1/1", branch_cnt, taken_cnt);
    end
    ei.bru_unsign = 1'b1;
    drive(ei, 32'hFFFFFFFF, 32'h1, 32'h100);
    n_vec++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h120) begin
      n_err++;
      $display("FAIL bltu: rv=%b pc=%h, required 0/00000120", redirect_valid, redirect_pc);
    end
    step();
    n_vec++;
    if (branch_cnt !== 32'd2 || taken_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL bltu_cnt: bc=%0d tc=%0d, required 2/1", branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_jalr();
    ei = '0; ei.bru_en = 1'b1; ei.bru_op = BRU_JALR; ei.imm = 32'h4;
    ei.rd_wren = 1'b1; ei.rd_addr = 5'd1; ei.op_b_sel = 1'b1;
    drive(ei, 32'h203, 32'h0, 32'h40);
    n_vec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h206) begin
      n_err++;
      $display("FAIL jalr_target: rv=%b pc=%h, required 1/00000206", redirect_valid, redirect_pc);
    end
    step();
    n_vec++;
    if (pipe.alu_result_M !== 32'h44 || branch_cnt !== 32'd3 || taken_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL jalr_link: alu=%h bc=%0d tc=%0d, required 00000044/3/2",
               pipe.alu_result_M, branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_stall();
    ei = '0; ei.bru_en = 1'b1; ei.bru_op = BRU_EQ; ei.imm = 32'h8; ei.alu_ctrl = ALU_ADD;
    stall_E = 1'b1;
    drive(ei, 32'h5, 32'h5, 32'h200);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (redirect_valid !== 1'b0 || redirect_pc !== 32'h208) begin
        n_err++;
        $display("FAIL stall_redirect[%0d]: rv=%b pc=%h, required 0/00000208", c, redirect_valid, redirect_pc);
      end
      step();
      n_vec++;
      if (pipe.alu_result_M !== 32'h44 || pipe.pc_M !== 32'h40 || pipe.memory_signals.rd_addr !== 5'd1 ||
          branch_cnt !== 32'd3 || taken_cnt !== 32'd2) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: alu=%h pc=%h rd=%0d bc=%0d tc=%0d, required 00000044/00000040/1/3/2",
                 c, pipe.alu_result_M, pipe.pc_M, pipe.memory_signals.rd_addr, branch_cnt, taken_cnt);
      end
    end
    stall_E = 1'b0;
    #1;
    n_vec++;
    if (redirect_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release_rv: got %b, required 1", redirect_valid);
    end
    step();
    n_vec++;
    if (branch_cnt !== 32'd4 || taken_cnt !== 32'd3 || pipe.alu_result_M !== 32'd10 || pipe.pc_M !== 32'h200) begin
      n_err++;
      $display("FAIL stall_release: bc=%0d tc=%0d alu=%h pc=%h, required 4/3/0000000a/00000200",
               branch_cnt, taken_cnt, pipe.alu_result_M, pipe.pc_M);
    end
  endtask

  task automatic test_flush();
    ei = '0; ei.alu_ctrl = ALU_ADD; ei.op_b_sel = 1'b1; ei.imm = 32'h8;
    ei.mem_wren = 1'b1; ei.mem_size = 2'd2; ei.rd_wren = 1'b1; ei.rd_addr = 5'd9; ei.mem_load = 1'b1;
    flush_E = 1'b1;
    drive(ei, 32'h10, 32'hCAFE, 32'h300);
    n_vec++;
    if (mem_load_E !== 1'b1) begin
      n_err++;
      $display("FAIL mem_load_E: got %b, required 1", mem_load_E);
    end
    step();
    n_vec++;
    if (pipe.memory_signals !== '0 || pipe.alu_result_M !== 32'h0 || pipe.store_data_M !== 32'h0) begin
      n_err++;
      $display("FAIL flush_bubble: mem=%h alu=%h st=%h, required 0/0/0",
               pipe.memory_signals, pipe.alu_result_M, pipe.store_data_M);
    end
    flush_E = 1'b0;
    step();
    me = '0; me.rd_wren = 1'b1; me.rd_addr = 5'd9; me.mem_wren = 1'b1; me.mem_size = 2'd2; me.mem_load = 1'b1;
    n_vec++;
    if (pipe.memory_signals !== me || pipe.alu_result_M !== 32'h18 || pipe.store_data_M !== 32'hCAFE ||
        pipe.pc_M !== 32'h300) begin
      n_err++;
      $display("FAIL store_load: mem=%h alu=%h st=%h pc=%h, required %h/00000018/0000cafe/00000300",
               pipe.memory_signals, pipe.alu_result_M, pipe.store_data_M, pipe.pc_M, me);
    end
    flush_E = 1'b1; stall_E = 1'b1;
    ei = '0;
    drive(ei, 32'h1, 32'h2, 32'h400);
    step();
    n_vec++;
    if (pipe.memory_signals !== me || pipe.store_data_M !== 32'hCAFE || pipe.pc_M !== 32'h300) begin
      n_err++;
      $display("FAIL flush_stall_hold: mem=%h st=%h pc=%h, required %h/0000cafe/00000300",
               pipe.memory_signals, pipe.store_data_M, pipe.pc_M, me);
    end
    stall_E = 1'b0;
    ei = '0; ei.bru_en = 1'b1; ei.bru_op = BRU_NE; ei.imm = 32'h40;
    drive(ei, 32'h1, 32'h2, 32'h500);
    step();
    flush_E = 1'b0;
    n_vec++;
    if (branch_cnt !== 32'd5 || taken_cnt !== 32'd4 || pipe.memory_signals !== '0) begin
      n_err++;
      $display("FAIL flush_counts: bc=%0d tc=%0d mem=%h, required 5/4/0", branch_cnt, taken_cnt, pipe.memory_signals);
    end
  endtask

  task automatic test_bubble();
    ei = '0;
    drive(ei, 32'h3, 32'h3, 32'h600);
    n_vec++;
    if (redirect_valid !== 1'b0 || rd_wren_E !== 1'b0 || mem_load_E !== 1'b0) begin
      n_err++;
      $display("FAIL bubble_comb: rv=%b rdw=%b ml=%b, required 0/0/0", redirect_valid, rd_wren_E, mem_load_E);
    end
    step();
    n_vec++;
    if (branch_cnt !== 32'd5 || taken_cnt !== 32'd4 || pipe.memory_signals !== '0) begin
      n_err++;
      $display("FAIL bubble_reg: bc=%0d tc=%0d mem=%h, required 5/4/0", branch_cnt, taken_cnt, pipe.memory_signals);
    end
  endtask

  task automatic test_reset_mid();
    ei = '0; ei.alu_ctrl = ALU_ADD; ei.rd_wren = 1'b1; ei.rd_addr = 5'd7;
    drive(ei, 32'h11, 32'h22, 32'h700);
    step();
    #1;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (pipe.memory_signals !== '0 || pipe.alu_result_M !== 32'h0 || pipe.store_data_M !== 32'h0 ||
        pipe.pc_M !== 32'h0 || branch_cnt !== 32'h0 || taken_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid: mem=%h alu=%h st=%h pc=%h bc=%0d tc=%0d, required all 0",
               pipe.memory_signals, pipe.alu_result_M, pipe.store_data_M, pipe.pc_M, branch_cnt, taken_cnt);
    end
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_fwd();
    test_alu_ops();
    test_blt();
    test_jalr();
    test_stall();
    test_flush();
    test_bubble();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
